// File: rtl/pq_pkg.sv
// rtl/pq_pkg.sv - key/value item type shared by the register-array priority queue
package pq_pkg;

   localparam int KEY_W = 16;
   localparam int VAL_W = 16;

   typedef struct packed {
      logic [KEY_W-1:0] key;
      logic [VAL_W-1:0] val;
   } kv_t;

   // An empty slot carries the largest key so it always sorts behind real items.
   localparam logic [KEY_W-1:0] KEY0 = '1;
   localparam logic [VAL_W-1:0] VAL0 = '0;

endpackage

// File: rtl/ra_pq_reg_stage.sv
// rtl/ra_pq_reg_stage.sv - one key/value register with valid bit, load and clear enables
module ra_pq_reg_stage
   import pq_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr,
   input  logic                    load,
   input  logic                    d_valid,
   input  logic [$bits(kv_t)-1:0]  d_kv,
   output logic                    q_valid,
   output logic [$bits(kv_t)-1:0]  q_kv
);

   // Loading an invalid source writes the empty value so idle data stays defined.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_valid <= 1'b0;
         q_kv    <= {KEY0, VAL0};
      end else if (clr || (load && !d_valid)) begin
         q_valid <= 1'b0;
         q_kv    <= {KEY0, VAL0};
      end else if (load) begin
         q_valid <= 1'b1;
         q_kv    <= d_kv;
      end
   end

endmodule

// File: rtl/ra_pq_reg_pipe.sv
// rtl/ra_pq_reg_pipe.sv - elastic DEPTH-stage key/value register pipe with bubble collapse
module ra_pq_reg_pipe
   import pq_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int CW    = $clog2(DEPTH + 1)
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic                    in_valid,
   input  logic [$bits(kv_t)-1:0]  in_kv,
   output logic                    in_ready,
   output logic                    out_valid,
   output logic [$bits(kv_t)-1:0]  out_kv,
   input  logic                    out_ready,
   output logic [CW-1:0]           count
);

   localparam int KV_W = $bits(kv_t);

   logic [DEPTH-1:0] valid;
   logic [DEPTH-1:0] adv;
   logic [KV_W-1:0]  data [DEPTH];
   logic             hole_seen;
   logic             in_xfer;
   logic             out_xfer;
   logic [CW-1:0]    cnt;

   // A stage may move when the output drains or any stage at or beyond it is empty.
   always_comb begin
      adv       = '0;
      hole_seen = 1'b0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         hole_seen = hole_seen | ~valid[i];
         adv[i]    = out_ready | hole_seen;
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      logic            src_valid;
      logic [KV_W-1:0] src_kv;

      if (g == 0) begin : g_head
         assign src_valid = in_valid;
         assign src_kv    = in_kv;
      end else begin : g_body
         assign src_valid = valid[g-1];
         assign src_kv    = data[g-1];
      end

      ra_pq_reg_stage u_stage (
         .clk     (clk),
         .rst_n   (rst_n),
         .clr     (flush),
         .load    (adv[g]),
         .d_valid (src_valid),
         .d_kv    (src_kv),
         .q_valid (valid[g]),
         .q_kv    (data[g])
      );
   end

   assign in_ready  = adv[0];
   assign out_valid = valid[DEPTH-1];
   assign out_kv    = data[DEPTH-1];
   assign in_xfer   = in_valid & in_ready;
   assign out_xfer  = out_valid & out_ready;
   assign count     = cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (flush) begin
         cnt <= '0;
      end else if (in_xfer && !out_xfer) begin
         cnt <= cnt + 1'b1;
      end else if (out_xfer && !in_xfer) begin
         cnt <= cnt - 1'b1;
      end
   end

   a_count_popcount: assert property (@(posedge clk) disable iff (!rst_n)
      cnt == CW'($countones(valid)));

   a_in_kv_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (in_valid && !in_ready && !flush) |=> $stable(in_kv));

endmodule

// File: doc/ra_pq_reg_pipe.md
Name: ra_pq_reg_pipe

Overview:
- Parametrised, elastic successor to the single key-value register used in the register-array priority queue.
- Moves kv_t items through DEPTH register stages with a per-stage valid bit and a valid/ready handshake; empty stages are collapsed, so no bubbles persist.
- Adds synchronous flush and an occupancy count.
- Sits between the priority-queue core and its consumers, or between register-array banks, as a retiming / decoupling stage.

Parameters:
- DEPTH, 4, number of register stages (1..16); stage 0 is the input side, stage DEPTH-1 the output side.
- CW, $clog2(DEPTH+1), width of the occupancy count (derived; not overridden).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- flush  in  1  synchronous clear of all stages.
- in_valid  in  1  upstream offers in_kv.
- in_kv  in  $bits(kv_t)  offered item.
- in_ready  out  1  pipe accepts in_kv this cycle.
- out_valid  out  1  out_kv holds a valid item.
- out_kv  out  $bits(kv_t)  item at stage DEPTH-1.
- out_ready  in  1  downstream takes out_kv this cycle.
- count  out  CW  number of valid stages (0..DEPTH).

Behaviour:
- Reset (rst_n low, asynchronous):
  - all stage data = {KEY0,VAL0}, all valid = 0;
  - out_valid = 0, out_kv = {KEY0,VAL0}, count = 0;
  - in_ready = 1 combinationally (pipe empty).
- Reset deasserting mid-transfer: in-flight items are lost; there is no partial state.
- Stage advance rule: adv[DEPTH-1] = out_ready | ~valid[DEPTH-1]; adv[i] = adv[i+1] | ~valid[i].
- in_ready = adv[0]. This is a combinational chain from out_ready, which is acceptable for DEPTH ≤ 16.
- On a rising edge with adv[i] = 1:
  - stage i loads stage i-1 (stage 0 loads in_kv / in_valid);
  - a stage whose source is invalid loads {KEY0,VAL0} with valid 0, so idle data is always the defined empty value.
- Stages with adv[i] = 0 hold both data and valid.
- Transfers:
  - input transfer = in_valid & in_ready;
  - output transfer = out_valid & out_ready.
- Latency: an item accepted at edge E appears on out_kv with out_valid = 1 after edge E+DEPTH-1, if no stall.
- Throughput: 1 item/cycle when out_ready is held high.
- Stall (out_ready = 0):
  - items compact toward the output; empty stages ahead of a valid item still advance (bubble collapse);
  - in_ready drops only when all DEPTH stages are valid.
- Full (count = DEPTH):
  - in_ready = out_ready, so simultaneous in and out transfers are allowed and count stays DEPTH;
  - in_kv must not be lost or duplicated.
- Empty (count = 0): out_valid = 0, out_kv = {KEY0,VAL0}.
- count update each edge:
  - +1 on input transfer only;
  - -1 on output transfer only;
  - unchanged when both or neither occur.
  - count is a register, not derived by popcount, and must always equal the popcount of the valid bits (assertion).
- Ordering: items leave in acceptance order (FIFO); keys are never compared or reordered here.
- Flush (synchronous) clears every stage to {KEY0,VAL0}/invalid and sets count = 0 on the next edge.
  - Flush overrides any input or output transfer in the same cycle; an item offered then is dropped.
  - in_ready is still computed normally during flush; the upstream must treat a flush-cycle handshake as discarded.
- Protocol: upstream must hold in_kv stable while in_valid & ~in_ready (assertion only; not checked in RTL).

Decomposition:
- pq_pkg provides kv_t, KEY0 and VAL0 (existing); no new package items are needed.
- One natural sub-module: ra_pq_reg_stage.
  - Contents: one kv_t register plus its valid bit, with async active-low reset and load/clear enables.
  - Instantiated DEPTH times in a generate loop.
- The advance chain and count logic live in the top module.

Test Plan:
1. Reset with rst_n = 0 asserted mid-stream (pipe holding 3 items) -> immediately out_valid = 0, count = 0, out_kv = {KEY0,VAL0}; after release, in_ready = 1.
2. DEPTH = 4, out_ready = 1, push keys 10, 20, 30 on consecutive cycles -> key 10 on out_kv 3 edges after its accept, then 20 and 30 on successive cycles, count peaks at 3.
3. out_ready = 0, push 5 items -> first 4 accepted, in_ready = 0 on the 5th, count = 4, out_kv = first key. Raise out_ready while in_valid stays high -> one in and one out per cycle, count stays 4, order preserved.
4. Bubble collapse: push key 7, idle 2 cycles, push key 9 with out_ready = 0 -> key 9 reaches stage 2 (adjacent to 7), count = 2, no gap remains.
5. Flush with count = 3 and in_valid = 1 in the same cycle -> next cycle count = 0, out_valid = 0, the offered item does not appear later.
6. DEPTH = 1 build, random in_valid/out_ready for 1000 cycles against a reference FIFO model -> identical output sequence; count always matches the valid-bit popcount.
